// File: rtl/hilo_pkg.sv
// rtl/hilo_pkg.sv - shared types and constants for the HI/LO divide sequencer
// Contents:
//   div_state_t   sequencer state (IDLE, BYZERO, RUN, DONE)
//   DIV_W         native operand width (N_REG)
//   DIV_ITER      restoring steps per divide at the native width
//   div_result_t  HI/LO write data pair (remainder, quotient)
package hilo_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    BYZERO = 2'd1,
    RUN    = 2'd2,
    DONE   = 2'd3
  } div_state_t;

  localparam int DIV_W    = 32;
  localparam int DIV_ITER = DIV_W;

  typedef struct packed {
    logic [DIV_W-1:0] hi;
    logic [DIV_W-1:0] lo;
  } div_result_t;

endpackage

// File: rtl/div_step.sv
// rtl/div_step.sv - one restoring-division step (shift, trial subtract, restore)
// Ports:
//   i_rem  in  W  partial remainder before the step
//   i_quo  in  W  dividend/quotient shift register before the step
//   i_dvs  in  W  divisor magnitude
//   o_rem  out W  partial remainder after the step
//   o_quo  out W  quotient shift register after the step (new bit in LSB)
module div_step #(
  parameter int W = 32
) (
  input  logic [W-1:0] i_rem,
  input  logic [W-1:0] i_quo,
  input  logic [W-1:0] i_dvs,
  output logic [W-1:0] o_rem,
  output logic [W-1:0] o_quo
);

  logic [W:0] shifted;
  logic [W:0] trial;
  logic       ge;

  // {rem,quo} shifted left: the dividend MSB moves into the remainder.
  assign shifted = {i_rem, i_quo[W-1]};
  assign trial   = shifted - {1'b0, i_dvs};

  // The remainder entering a step is always below the divisor, so when
  // shifted[W] is set the difference is positive and smaller than 2^W;
  // trial[W] is therefore a borrow flag in every case.
  assign ge = ~trial[W];

  assign o_rem = ge ? trial[W-1:0] : shifted[W-1:0];
  assign o_quo = {i_quo[W-2:0], ge};

endmodule

// File: rtl/hilo_div_seq.sv
// rtl/hilo_div_seq.sv - multi-cycle DIV/DIVU sequencer producing HI/LO write data
// Ports:
//   i_clk        in  1  clock
//   i_rst_n      in  1  asynchronous active-low reset
//   i_start      in  1  divide request, held until o_ready
//   i_signed     in  1  1 = DIV (two's complement), 0 = DIVU
//   i_annul      in  1  pipeline flush, aborts the operation
//   i_dividend   in  W  rs operand
//   i_divisor    in  W  rt operand
//   o_lo         out W  quotient (valid while o_ready)
//   o_hi         out W  remainder (valid while o_ready)
//   o_ready      out 1  result valid
//   o_stall_req  out 1  pipeline stall request
//   o_busy       out 1  operation in flight (BYZERO or RUN)
module hilo_div_seq
  import hilo_pkg::*;
#(
  parameter int W = DIV_ITER
) (
  input  logic         i_clk,
  input  logic         i_rst_n,
  input  logic         i_start,
  input  logic         i_signed,
  input  logic         i_annul,
  input  logic [W-1:0] i_dividend,
  input  logic [W-1:0] i_divisor,
  output logic [W-1:0] o_lo,
  output logic [W-1:0] o_hi,
  output logic         o_ready,
  output logic         o_stall_req,
  output logic         o_busy
);

  localparam int CW = $clog2(W);

  div_state_t state_q, state_d;

  logic [CW-1:0] cnt_q;
  logic [W-1:0]  rem_q, quo_q, dvs_q;
  logic          neg_quo_q, neg_rem_q;
  logic [W-1:0]  lo_q, hi_q;
  logic [W-1:0]  rem_nx, quo_nx;
  logic          accept, last_step;

  function automatic logic [W-1:0] magnitude(input logic [W-1:0] v, input logic sgn);
    return (sgn && v[W-1]) ? -v : v;
  endfunction

  assign accept    = i_start && !i_annul;
  assign last_step = (cnt_q == CW'(W - 1));

  div_step #(.W(W)) u_step (
    .i_rem (rem_q),
    .i_quo (quo_q),
    .i_dvs (dvs_q),
    .o_rem (rem_nx),
    .o_quo (quo_nx)
  );

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    o_stall_req = 1'b0;
    o_busy      = 1'b0;
    o_ready     = 1'b0;
    case (state_q)
      IDLE: begin
        o_stall_req = accept;
        if (accept) begin
          state_d = (i_divisor == '0) ? BYZERO : RUN;
        end
      end
      BYZERO: begin
        o_stall_req = 1'b1;
        o_busy      = 1'b1;
        state_d     = i_annul ? IDLE : DONE;
      end
      RUN: begin
        o_stall_req = 1'b1;
        o_busy      = 1'b1;
        if (i_annul) begin
          state_d = IDLE;
        end else if (last_step) begin
          state_d = DONE;
        end
      end
      DONE: begin
        o_ready = 1'b1;
        if (i_annul || !i_start) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Working registers only move in IDLE (latch) and RUN (step); the
  // result registers only change on entry to DONE, so an annulled
  // operation leaves the previous HI/LO visible.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      cnt_q     <= '0;
      rem_q     <= '0;
      quo_q     <= '0;
      dvs_q     <= '0;
      neg_quo_q <= 1'b0;
      neg_rem_q <= 1'b0;
      lo_q      <= '0;
      hi_q      <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (accept) begin
            cnt_q     <= '0;
            rem_q     <= '0;
            quo_q     <= magnitude(i_dividend, i_signed);
            dvs_q     <= magnitude(i_divisor, i_signed);
            neg_quo_q <= i_signed && (i_dividend[W-1] ^ i_divisor[W-1]);
            neg_rem_q <= i_signed && i_dividend[W-1];
          end
        end
        BYZERO: begin
          if (!i_annul) begin
            lo_q <= '0;
            hi_q <= '0;
          end
        end
        RUN: begin
          if (!i_annul) begin
            rem_q <= rem_nx;
            quo_q <= quo_nx;
            cnt_q <= cnt_q + CW'(1);
            if (last_step) begin
              lo_q <= neg_quo_q ? -quo_nx : quo_nx;
              hi_q <= neg_rem_q ? -rem_nx : rem_nx;
            end
          end
        end
        default: ;
      endcase
    end
  end

  assign o_lo = lo_q;
  assign o_hi = hi_q;

endmodule

// File: tb/tb_hilo_div_seq.sv
// tb/tb_hilo_div_seq.sv - self-checking bench for hilo_div_seq
module tb_hilo_div_seq;
  import hilo_pkg::*;

  localparam int W = 32;

  logic         i_clk = 1'b0;
  logic         i_rst_n = 1'b0;
  logic         i_start = 1'b0;
  logic         i_signed = 1'b0;
  logic         i_annul = 1'b0;
  logic [W-1:0] i_dividend = '0;
  logic [W-1:0] i_divisor = '0;
  logic [W-1:0] o_lo, o_hi;
  logic         o_ready, o_stall_req, o_busy;

  int n_checks = 0;
  int n_errors = 0;

  hilo_div_seq #(.W(W)) dut (
    .i_clk       (i_clk),
    .i_rst_n     (i_rst_n),
    .i_start     (i_start),
    .i_signed    (i_signed),
    .i_annul     (i_annul),
    .i_dividend  (i_dividend),
    .i_divisor   (i_divisor),
    .o_lo        (o_lo),
    .o_hi        (o_hi),
    .o_ready     (o_ready),
    .o_stall_req (o_stall_req),
    .o_busy      (o_busy)
  );

  always #5 i_clk = ~i_clk;

  initial begin
    #2000000;
    $display("FAIL timeout: simulation exceeded time limit");
    $fatal(1, "timeout");
  end

  typedef struct {
    string       name;
    logic        sgn;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] lo;
    logic [31:0] hi;
  } vec_t;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
    end
  endtask

  // Reference: plain integer arithmetic (truncating division, remainder
  // follows the dividend) with the architectural divide-by-zero result.
  function automatic div_result_t ref_div(input logic sgn, input logic [31:0] a, input logic [31:0] b);
    div_result_t r;
    longint sa, sb, q, m;
    if (b == 0) begin
      r.lo = '0;
      r.hi = '0;
      return r;
    end
    sa = sgn ? longint'($signed(a)) : longint'(a);
    sb = sgn ? longint'($signed(b)) : longint'(b);
    q = sa / sb;
    m = sa % sb;
    r.lo = q[31:0];
    r.hi = m[31:0];
    return r;
  endfunction

  task automatic wait_ready(output int lat, output int busy_n, output bit stall_bad);
    lat = 0;
    busy_n = 0;
    stall_bad = 0;
    while (lat < 40) begin
      @(posedge i_clk);
      #1;
      lat++;
      if (o_ready) break;
      if (!o_stall_req) stall_bad = 1;
      if (o_busy) busy_n++;
    end
  endtask

  task automatic run_div(input string nm, input logic sgn, input logic [31:0] a, input logic [31:0] b,
                         input logic [31:0] elo, input logic [31:0] ehi);
    int lat, busy_n, elat;
    bit stall_bad;
    elat = (b == 0) ? 2 : W + 1;
    @(negedge i_clk);
    i_start = 1'b1;
    i_annul = 1'b0;
    i_signed = sgn;
    i_dividend = a;
    i_divisor = b;
    #1;
    chk({nm, " stall_at_request"}, 64'(o_stall_req), 64'd1);
    wait_ready(lat, busy_n, stall_bad);
    chk({nm, " latency"}, 64'(lat), 64'(elat));
    chk({nm, " busy_cycles"}, 64'(busy_n), 64'(elat - 1));
    chk({nm, " stall_while_busy"}, 64'(stall_bad), 64'd0);
    chk({nm, " lo"}, 64'(o_lo), 64'(elo));
    chk({nm, " hi"}, 64'(o_hi), 64'(ehi));
    chk({nm, " stall_in_done"}, 64'(o_stall_req), 64'd0);
    // Operand changes after latching must not disturb the held result.
    @(negedge i_clk);
    i_dividend = ~a;
    i_divisor = b + 32'd1;
    @(posedge i_clk);
    #1;
    chk({nm, " hold_in_done"}, {o_ready, o_lo, o_hi[30:0]}, {1'b1, elo, ehi[30:0]});
    @(negedge i_clk);
    i_start = 1'b0;
    @(posedge i_clk);
    #1;
    chk({nm, " ready_drop"}, 64'(o_ready), 64'd0);
  endtask

  vec_t vecs[$];
  div_result_t rr;
  logic [31:0] prev_lo, prev_hi;
  int lat, busy_n;
  bit stall_bad, ready_seen;

  initial begin
    vecs.push_back('{"u100_7",    1'b0, 32'd100,        32'd7,          32'd14,         32'd2});
    vecs.push_back('{"s-7_2",     1'b1, 32'hFFFF_FFF9,  32'd2,          32'hFFFF_FFFD,  32'hFFFF_FFFF});
    vecs.push_back('{"u_byzero",  1'b0, 32'h1234,       32'd0,          32'd0,          32'd0});
    vecs.push_back('{"s_ovf",     1'b1, 32'h8000_0000,  32'hFFFF_FFFF,  32'h8000_0000,  32'd0});
    vecs.push_back('{"u_max_1",   1'b0, 32'hFFFF_FFFF,  32'd1,          32'hFFFF_FFFF,  32'd0});
    vecs.push_back('{"s-100_7",   1'b1, 32'hFFFF_FF9C,  32'd7,          32'hFFFF_FFF2,  32'hFFFF_FFFE});
    vecs.push_back('{"s100_-7",   1'b1, 32'd100,        32'hFFFF_FFF9,  32'hFFFF_FFF2,  32'd2});
    vecs.push_back('{"u5_max",    1'b0, 32'd5,          32'hFFFF_FFFF,  32'd0,          32'd5});
    vecs.push_back('{"s_byzero",  1'b1, 32'h8000_0000,  32'd0,          32'd0,          32'd0});
    vecs.push_back('{"u0_5",      1'b0, 32'd0,          32'd5,          32'd0,          32'd0});

    #1;
    chk("reset ready", 64'(o_ready), 64'd0);
    chk("reset busy", 64'(o_busy), 64'd0);
    chk("reset lo_hi", {o_lo, o_hi}, 64'd0);
    @(negedge i_clk);
    i_rst_n = 1'b1;

    for (int i = 0; i < vecs.size(); i++) begin
      run_div(vecs[i].name, vecs[i].sgn, vecs[i].a, vecs[i].b, vecs[i].lo, vecs[i].hi);
    end

    for (int i = 0; i < 40; i++) begin
      logic s;
      logic [31:0] a, b;
      s = 1'($urandom_range(0, 1));
      a = $urandom;
      case ($urandom_range(0, 3))
        0: b = 32'($urandom_range(0, 15));
        1: b = $urandom >> $urandom_range(0, 31);
        2: b = -32'($urandom_range(1, 9));
        default: b = $urandom;
      endcase
      rr = ref_div(s, a, b);
      run_div($sformatf("rand%0d", i), s, a, b, rr.lo, rr.hi);
    end

    // Annul in RUN at count 10: back to IDLE, result registers untouched.
    run_div("pre_annul", 1'b0, 32'd50, 32'd6, 32'd8, 32'd2);
    prev_lo = o_lo;
    prev_hi = o_hi;
    @(negedge i_clk);
    i_start = 1'b1;
    i_signed = 1'b0;
    i_dividend = 32'd100;
    i_divisor = 32'd7;
    ready_seen = 0;
    for (int k = 0; k < 11; k++) begin
      @(posedge i_clk);
      #1;
      if (o_ready) ready_seen = 1;
    end
    chk("annul pre busy", 64'(o_busy), 64'd1);
    @(negedge i_clk);
    i_annul = 1'b1;
    @(posedge i_clk);
    #1;
    if (o_ready) ready_seen = 1;
    chk("annul busy_drop", 64'(o_busy), 64'd0);
    chk("annul ready_never", 64'(ready_seen), 64'd0);
    chk("annul stall_blocked", 64'(o_stall_req), 64'd0);
    chk("annul lo_hi_held", {o_lo, o_hi}, {prev_lo, prev_hi});
    run_div("after_annul_9_3", 1'b0, 32'd9, 32'd3, 32'd3, 32'd0);

    // Annul in DONE with start still high forces IDLE.
    @(negedge i_clk);
    i_start = 1'b1;
    i_dividend = 32'd20;
    i_divisor = 32'd3;
    wait_ready(lat, busy_n, stall_bad);
    chk("done_annul ready", 64'(o_ready), 64'd1);
    @(negedge i_clk);
    i_annul = 1'b1;
    @(posedge i_clk);
    #1;
    chk("done_annul exit", {62'd0, o_ready, o_busy}, 64'd0);
    chk("done_annul result", {o_lo, o_hi}, {32'd6, 32'd2});
    @(negedge i_clk);
    i_annul = 1'b0;
    i_start = 1'b0;

    // Asynchronous reset mid-RUN, start held across the pulse.
    @(negedge i_clk);
    i_start = 1'b1;
    i_signed = 1'b1;
    i_dividend = 32'hFFFF_FFF9;
    i_divisor = 32'd2;
    repeat (6) @(posedge i_clk);
    #2;
    chk("rst pre busy", 64'(o_busy), 64'd1);
    i_rst_n = 1'b0;
    #1;
    chk("async_rst outputs", {o_lo, o_hi}, 64'd0);
    chk("async_rst flags", {62'd0, o_ready, o_busy}, 64'd0);
    @(negedge i_clk);
    i_rst_n = 1'b1;
    wait_ready(lat, busy_n, stall_bad);
    chk("rst_restart latency", 64'(lat), 64'(W + 1));
    chk("rst_restart result", {o_lo, o_hi}, {32'hFFFF_FFFD, 32'hFFFF_FFFF});
    @(negedge i_clk);
    i_start = 1'b0;
    @(posedge i_clk);
    #1;

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
